// File: rtl/strip_frame_scheduler.sv
// rtl/strip_frame_scheduler.sv - LED strip frame scheduler: fetches pixels, feeds the serial encoder, enforces latch gap
//
// Ports:
//   clock_12mhz, reset_n     clock and asynchronous active-low reset
//   frame_request            level input; each 0->1 transition asks for one frame
//   encoder_done             one-cycle pulse, current word has been shifted out
//   mem_data_in[23:0]        frame RAM read data, valid the cycle after mem_read_en
//   mem_addr[7:0]            frame RAM read address (LED index)
//   mem_read_en              frame RAM read strobe (registered)
//   parallel_data_out[23:0]  word held for the encoder from encoder_start to encoder_done
//   encoder_start            one-cycle pulse starting the encoder (registered)
//   busy                     high whenever the scheduler is not idle
//   frame_done               one-cycle pulse in the last cycle of the latch gap
//   frame_overrun            one-cycle pulse when a request has to be dropped
//   test_pattern             only with STRIP_TEST_PATTERN_EN: send 24'h808080 without reading RAM
//
// Optional feature macro: STRIP_TEST_PATTERN_EN

module strip_frame_scheduler #(
  parameter int LED_COUNT    = 60,
  parameter int LATCH_CYCLES = 960
) (
  input  logic        clock_12mhz,
  input  logic        reset_n,
  input  logic        frame_request,
  input  logic        encoder_done,
  input  logic [23:0] mem_data_in,
`ifdef STRIP_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [7:0]  mem_addr,
  output logic        mem_read_en,
  output logic [23:0] parallel_data_out,
  output logic        encoder_start,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_overrun
);

  localparam int LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LCW-1:0] LATCH_LAST   = LCW'(LATCH_CYCLES - 1);
  // frame_done is registered, so it is armed one count before the final latch cycle
  localparam logic [LCW-1:0] LATCH_PENULT = LCW'((LATCH_CYCLES > 1) ? LATCH_CYCLES - 2 : 0);
  localparam logic           LATCH_ONE    = (LATCH_CYCLES == 1);
  localparam logic [7:0]     LED_LAST     = 8'(LED_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_START,
    S_SEND,
    S_LATCH
  } state_t;

  state_t         state;
  logic [7:0]     led_index;
  logic [LCW-1:0] latch_count;
  logic           pending;
  logic           req_q;
  logic           armed;
  logic           req_edge;
  logic           fetch_en;
  logic [23:0]    capture_word;

`ifdef STRIP_TEST_PATTERN_EN
  assign fetch_en     = ~test_pattern;
  assign capture_word = test_pattern ? 24'h808080 : mem_data_in;
`else
  assign fetch_en     = 1'b1;
  assign capture_word = mem_data_in;
`endif

  // armed stays low for the first cycle after reset so a request that was
  // already high during reset is not mistaken for a new edge
  assign req_edge = armed & frame_request & ~req_q;

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      led_index         <= 8'd0;
      latch_count       <= '0;
      pending           <= 1'b0;
      req_q             <= 1'b0;
      armed             <= 1'b0;
      mem_addr          <= 8'd0;
      mem_read_en       <= 1'b0;
      parallel_data_out <= 24'd0;
      encoder_start     <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      frame_overrun     <= 1'b0;
    end else begin
      req_q         <= frame_request;
      armed         <= 1'b1;
      mem_read_en   <= 1'b0;
      encoder_start <= 1'b0;
      frame_done    <= 1'b0;
      frame_overrun <= 1'b0;

      // one request can be queued behind the running frame; a further one is dropped
      if (req_edge && state != S_IDLE) begin
        if (pending) frame_overrun <= 1'b1;
        else         pending       <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          led_index <= 8'd0;
          if (req_edge || pending) begin
            // an edge coinciding with a queued request stays queued
            pending     <= req_edge & pending;
            state       <= S_FETCH;
            busy        <= 1'b1;
            mem_addr    <= 8'd0;
            mem_read_en <= fetch_en;
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          parallel_data_out <= capture_word;
          encoder_start     <= 1'b1;
          state             <= S_START;
        end
        S_START: state <= S_SEND;
        S_SEND: begin
          if (encoder_done) begin
            if (led_index == LED_LAST) begin
              state       <= S_LATCH;
              latch_count <= '0;
              frame_done  <= LATCH_ONE;
            end else begin
              led_index   <= led_index + 8'd1;
              mem_addr    <= led_index + 8'd1;
              mem_read_en <= fetch_en;
              state       <= S_FETCH;
            end
          end
        end
        S_LATCH: begin
          if (latch_count == LATCH_LAST) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            latch_count <= '0;
          end else begin
            latch_count <= latch_count + LCW'(1);
            if (latch_count == LATCH_PENULT) frame_done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_strip_frame_scheduler.sv
// tb/tb_strip_frame_scheduler.sv - directed self-checking bench for strip_frame_scheduler

module tb_strip_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_request;
  logic        encoder_done;
  logic [23:0] mem_data_in;
  logic [7:0]  mem_addr;
  logic        mem_read_en;
  logic [23:0] parallel_data_out;
  logic        encoder_start;
  logic        busy;
  logic        frame_done;
  logic        frame_overrun;
`ifdef STRIP_TEST_PATTERN_EN
  logic        test_pattern;
`endif

  always #5 clk = ~clk;

  strip_frame_scheduler #(
    .LED_COUNT   (3),
    .LATCH_CYCLES(8)
  ) dut (
    .clock_12mhz      (clk),
    .reset_n          (reset_n),
    .frame_request    (frame_request),
    .encoder_done     (encoder_done),
    .mem_data_in      (mem_data_in),
`ifdef STRIP_TEST_PATTERN_EN
    .test_pattern     (test_pattern),
`endif
    .mem_addr         (mem_addr),
    .mem_read_en      (mem_read_en),
    .parallel_data_out(parallel_data_out),
    .encoder_start    (encoder_start),
    .busy             (busy),
    .frame_done       (frame_done),
    .frame_overrun    (frame_overrun)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [23:0] ram [0:2];
  logic [23:0] start_log [$];
  logic [7:0]  addr_log [$];
  int          done_log [$];
  int          cyc = 0;
  int          done_cnt, overrun_cnt, both_hi, last_done_cyc, enc_cnt;
  bit          enc_auto;
  int          c0, n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: RAM answers the cycle after a read strobe, encoder model answers
  // 10 cycles after each start, and observed outputs are logged.
  task automatic tick();
    logic       rd;
    logic [7:0] a;
    rd = mem_read_en;
    a  = mem_addr;
    @(posedge clk);
    #1;
    cyc++;
    mem_data_in  = rd ? ((a < 8'd3) ? ram[a] : 24'h0) : 24'hA5A5A5;
    encoder_done = 1'b0;
    if (enc_auto && enc_cnt > 0) begin
      enc_cnt--;
      if (enc_cnt == 0) begin
        encoder_done = 1'b1;
        done_log.push_back(cyc);
      end
    end
    if (encoder_start) begin
      start_log.push_back(parallel_data_out);
      if (enc_auto) enc_cnt = 10;
    end
    if (mem_read_en) addr_log.push_back(mem_addr);
    if (frame_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (frame_overrun) overrun_cnt++;
    if (mem_read_en && encoder_start) both_hi++;
  endtask

  task automatic clear_logs();
    start_log.delete();
    addr_log.delete();
    done_log.delete();
    done_cnt    = 0;
    overrun_cnt = 0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int k;
    k = 0;
    while (done_cnt < target && k < 400) begin
      tick();
      k++;
    end
    check(tag, done_cnt >= target, 1);
  endtask

  initial begin
    reset_n       = 1'b0;
    frame_request = 1'b1;
    encoder_done  = 1'b0;
    mem_data_in   = 24'h0;
    enc_auto      = 1'b0;
    enc_cnt       = 0;
    both_hi       = 0;
    last_done_cyc = 0;
`ifdef STRIP_TEST_PATTERN_EN
    test_pattern  = 1'b0;
`endif
    ram[0] = 24'h0000FF;
    ram[1] = 24'h00FF00;
    ram[2] = 24'hFF0000;
    clear_logs();

    // reset state, with the request already high
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_read_en", mem_read_en, 0);
    check("rst_start", encoder_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", frame_overrun, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", parallel_data_out, 0);

    // request held high across reset release is not an edge
    reset_n = 1'b1;
    repeat (5) tick();
    check("no_edge_after_reset_busy", busy, 0);
    check("no_edge_after_reset_reads", addr_log.size(), 0);
    frame_request = 1'b0;
    tick();

    // single frame: 3 LEDs, encoder 10 cycles, latch 8
    enc_auto = 1'b1;
    clear_logs();
    c0 = cyc;
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    check("f1_busy", busy, 1);
    check("f1_first_read", mem_read_en, 1);
    wait_done(1, "f1_done_reached");
    check("f1_read_count", addr_log.size(), 3);
    check("f1_addr0", addr_log[0], 0);
    check("f1_addr1", addr_log[1], 1);
    check("f1_addr2", addr_log[2], 2);
    check("f1_start_count", start_log.size(), 3);
    check("f1_word0", start_log[0], 24'h0000FF);
    check("f1_word1", start_log[1], 24'h00FF00);
    check("f1_word2", start_log[2], 24'hFF0000);
    check("f1_latch_len", last_done_cyc - done_log[2], 8);
    check("f1_frame_len", last_done_cyc - c0, 47);
    tick();
    check("f1_idle_after", busy, 0);
    check("f1_done_one_cycle", frame_done, 0);

    // queued request during LED 1, then a dropped one
    clear_logs();
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    n = 0;
    while (start_log.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    tick();
    tick();
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    tick();
    check("pend_no_overrun", overrun_cnt, 0);
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    check("overrun_pulse", frame_overrun, 1);
    tick();
    check("overrun_one_cycle", frame_overrun, 0);
    wait_done(1, "f2_done_reached");
    tick();
    check("f2_idle_gap", busy, 0);
    tick();
    check("f3_fetch_start", mem_read_en, 1);
    check("f3_fetch_addr", mem_addr, 0);
    wait_done(2, "f3_done_reached");
    repeat (60) tick();
    check("one_extra_frame", done_cnt, 2);
    check("overrun_once", overrun_cnt, 1);
    check("f23_start_count", start_log.size(), 6);
    check("f3_idle_after", busy, 0);

    // stray encoder_done in IDLE and in LATCH
    enc_auto = 1'b0;
    encoder_done = 1'b1;
    tick();
    check("idle_done_busy", busy, 0);
    tick();
    check("idle_done_no_read", mem_read_en, 0);
    enc_auto = 1'b1;
    clear_logs();
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    n = 0;
    while (done_log.size() < 3 && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    encoder_done = 1'b1;
    tick();
    wait_done(1, "f4_done_reached");
    check("latch_done_ignored", last_done_cyc - done_log[2], 8);
    check("idle_done_no_advance", addr_log[0], 0);
    check("f4_read_count", addr_log.size(), 3);
    check("f4_start_count", start_log.size(), 3);
    tick();
    check("f4_idle_after", busy, 0);

    // reset during LATCH with a request queued
    clear_logs();
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    n = 0;
    while (start_log.size() < 1 && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    n = 0;
    while (done_log.size() < 3 && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    check("pre_reset_in_latch", busy, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_flags", {busy, mem_read_en, encoder_start, frame_done, frame_overrun}, 0);
    check("async_rst_addr", mem_addr, 0);
    check("async_rst_data", parallel_data_out, 0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_no_frame_done", done_cnt, 0);
    check("post_rst_no_start", start_log.size(), 3);

`ifdef STRIP_TEST_PATTERN_EN
    // test pattern: no RAM reads, every word 24'h808080
    clear_logs();
    test_pattern = 1'b1;
    frame_request = 1'b1;
    tick();
    frame_request = 1'b0;
    wait_done(1, "tp_done_reached");
    check("tp_no_reads", addr_log.size(), 0);
    check("tp_start_count", start_log.size(), 3);
    check("tp_word0", start_log[0], 24'h808080);
    check("tp_word1", start_log[1], 24'h808080);
    check("tp_word2", start_log[2], 24'h808080);
    test_pattern = 1'b0;
    repeat (3) tick();
`endif

    check("read_start_exclusive", both_hi, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
